// File: rtl/arcade_input_pkg.sv
// Shared constants, scan codes and types for the arcade player-input front end.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_A   = 2'd1,
        ROT_180 = 2'd2,
        ROT_B   = 2'd3
    } rot_t;

    typedef enum logic [1:0] {
        COIN_IDLE = 2'd0,
        COIN_HIGH = 2'd1,
        COIN_GAP  = 2'd2
    } coin_state_t;

    localparam int unsigned JOY_R = 0;
    localparam int unsigned JOY_L = 1;
    localparam int unsigned JOY_D = 2;
    localparam int unsigned JOY_U = 3;

    function automatic int unsigned joy_btn_idx(input int unsigned b);
        return 4 + b;
    endfunction

    function automatic int unsigned joy_start_idx(input int unsigned buttons);
        return 4 + buttons;
    endfunction

    function automatic int unsigned joy_coin_idx(input int unsigned buttons);
        return 5 + buttons;
    endfunction

    // Arrow keys match on the low byte only so the extended prefix is ignored.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [3:0][8:0] SC_BTN   = {9'h012, 9'h011, 9'h014, 9'h029};
    localparam logic [3:0][8:0] SC_START = {9'h00C, 9'h004, 9'h006, 9'h005};
    localparam logic [3:0][8:0] SC_COIN  = {9'h03E, 9'h03D, 9'h036, 9'h02E};
    localparam logic [8:0]      SC_PAUSE = 9'h04D;

    // Direction nibble layout: [0]R [1]L [2]D [3]U.
    function automatic logic [3:0] rotate_dir(input rot_t r, input logic [3:0] d);
        logic [3:0] o;
        case (r)
            ROT_A:   o = {d[JOY_L], d[JOY_R], d[JOY_D], d[JOY_U]};
            ROT_180: o = {d[JOY_D], d[JOY_U], d[JOY_R], d[JOY_L]};
            ROT_B:   o = {d[JOY_R], d[JOY_L], d[JOY_U], d[JOY_D]};
            default: o = d;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Per-player coin pulse generator: rising-edge request, fixed-width pulse, equal lockout.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 16
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic req,
    output logic coin
);

    localparam int unsigned CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_PULSE - 1);

    coin_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coin_q, coin_d;
    logic          req_q, req_d;
    logic          req_prev_q, req_prev_d;
    logic [1:0]    warm_q, warm_d;
    logic          rise;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        coin_d     = coin_q;
        req_d      = req;
        req_prev_d = req_q;
        warm_d     = {warm_q[0], 1'b1};
        // Edges are only trusted once both history flops hold real samples, so a
        // request already high across reset release is not taken as a new edge.
        rise       = req_q & ~req_prev_q & warm_q[1];
        unique case (state_q)
            COIN_IDLE: begin
                if (rise) begin
                    state_d = COIN_HIGH;
                    cnt_d   = CNT_LOAD;
                    coin_d  = 1'b1;
                end
            end
            COIN_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = COIN_GAP;
                    cnt_d   = CNT_LOAD;
                    coin_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COIN_GAP: begin
                if (cnt_q == '0) begin
                    state_d = COIN_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = COIN_IDLE;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= COIN_IDLE;
            cnt_q      <= '0;
            coin_q     <= 1'b0;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            warm_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coin_q     <= coin_d;
            req_q      <= req_d;
            req_prev_q <= req_prev_d;
            warm_q     <= warm_d;
        end
    end

    assign coin = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key map merged with HPS joysticks, rotation, coin and pause.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned BUTTONS    = 1,
    parameter int unsigned COIN_PULSE = 16
) (
    input  logic                         clk_sys,
    input  logic                         RESET_N,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joystick,
    input  logic [1:0]                   rot,
    input  logic                         merge_joys,
    input  logic                         coin_auto,
    output logic [4*PLAYERS-1:0]         p_dir,
    output logic [BUTTONS*PLAYERS-1:0]   p_btn,
    output logic [PLAYERS-1:0]           p_start,
    output logic [PLAYERS-1:0]           coin,
    output logic                         pause
);

    logic       ps2_tog_q, ps2_tog_d;
    logic       key_evt, key_make;
    logic [8:0] key_code;
    logic [3:0] kb_dir_q, kb_dir_d;
    logic [3:0] kb_btn_q, kb_btn_d;
    logic [3:0] kb_start_q, kb_start_d;
    logic [3:0] kb_coin_q, kb_coin_d;
    logic       pause_key_q, pause_key_d;
    logic       pause_q, pause_d;

    logic [4*PLAYERS-1:0]       p_dir_q, p_dir_d;
    logic [BUTTONS*PLAYERS-1:0] p_btn_q, p_btn_d;
    logic [PLAYERS-1:0]         p_start_q, p_start_d;
    logic [PLAYERS-1:0]         coin_req;

    logic [15:0] jv;
    logic [3:0]  raw_dir;
    logic        start_req;
    logic        unused_ok;

    assign key_evt  = ps2_key[10] ^ ps2_tog_q;
    assign key_make = ps2_key[9];
    assign key_code = ps2_key[8:0];

    always_comb begin
        ps2_tog_d   = ps2_key[10];
        kb_dir_d    = kb_dir_q;
        kb_btn_d    = kb_btn_q;
        kb_start_d  = kb_start_q;
        kb_coin_d   = kb_coin_q;
        pause_key_d = pause_key_q;
        pause_d     = pause_q;
        if (key_evt) begin
            if (key_code[7:0] == SC_UP)    kb_dir_d[JOY_U] = key_make;
            if (key_code[7:0] == SC_DOWN)  kb_dir_d[JOY_D] = key_make;
            if (key_code[7:0] == SC_LEFT)  kb_dir_d[JOY_L] = key_make;
            if (key_code[7:0] == SC_RIGHT) kb_dir_d[JOY_R] = key_make;
            for (int unsigned i = 0; i < 4; i++) begin
                if (key_code == SC_BTN[i])   kb_btn_d[i]   = key_make;
                if (key_code == SC_START[i]) kb_start_d[i] = key_make;
                if (key_code == SC_COIN[i])  kb_coin_d[i]  = key_make;
            end
            // Toggle only on the first make so typematic repeats are ignored.
            if (key_code == SC_PAUSE) begin
                pause_key_d = key_make;
                if (key_make && !pause_key_q) pause_d = ~pause_q;
            end
        end
    end

    always_comb begin
        p_dir_d   = '0;
        p_btn_d   = '0;
        p_start_d = '0;
        coin_req  = '0;
        jv        = '0;
        raw_dir   = '0;
        start_req = 1'b0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            jv = joystick[p*16 +: 16];
            if (p == 0 && merge_joys) begin
                for (int unsigned q = 1; q < PLAYERS; q++) jv = jv | joystick[q*16 +: 16];
            end
            raw_dir = jv[3:0];
            if (p == 0) raw_dir = raw_dir | kb_dir_q;
            p_dir_d[p*4 +: 4] = rotate_dir(rot_t'(rot), raw_dir);
            for (int unsigned b = 0; b < BUTTONS; b++) begin
                p_btn_d[p*BUTTONS + b] = (p == 0) ? (jv[joy_btn_idx(b)] | kb_btn_q[b])
                                                  : jv[joy_btn_idx(b)];
            end
            start_req    = jv[joy_start_idx(BUTTONS)] | kb_start_q[p];
            p_start_d[p] = start_req;
            coin_req[p]  = jv[joy_coin_idx(BUTTONS)] | kb_coin_q[p] | (coin_auto & start_req);
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            ps2_tog_q   <= 1'b0;
            kb_dir_q    <= '0;
            kb_btn_q    <= '0;
            kb_start_q  <= '0;
            kb_coin_q   <= '0;
            pause_key_q <= 1'b0;
            pause_q     <= 1'b0;
            p_dir_q     <= '0;
            p_btn_q     <= '0;
            p_start_q   <= '0;
        end else begin
            ps2_tog_q   <= ps2_tog_d;
            kb_dir_q    <= kb_dir_d;
            kb_btn_q    <= kb_btn_d;
            kb_start_q  <= kb_start_d;
            kb_coin_q   <= kb_coin_d;
            pause_key_q <= pause_key_d;
            pause_q     <= pause_d;
            p_dir_q     <= p_dir_d;
            p_btn_q     <= p_btn_d;
            p_start_q   <= p_start_d;
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_coin
        coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin (
            .clk_sys (clk_sys),
            .RESET_N (RESET_N),
            .req     (coin_req[g]),
            .coin    (coin[g])
        );
    end

    assign p_dir   = p_dir_q;
    assign p_btn   = p_btn_q;
    assign p_start = p_start_q;
    assign pause   = pause_q;

    // Joystick bits above the coin bit and key-map slots beyond PLAYERS/BUTTONS are spare.
    assign unused_ok = ^{joystick, kb_btn_q, kb_start_q, kb_coin_q};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with PLAYERS=2, BUTTONS=2, COIN_PULSE=4.
module tb_arcade_input_mapper;

    localparam int unsigned PLAYERS    = 2;
    localparam int unsigned BUTTONS    = 2;
    localparam int unsigned COIN_PULSE = 4;

    logic                       clk_sys = 1'b0;
    logic                       RESET_N;
    logic [10:0]                ps2_key;
    logic [16*PLAYERS-1:0]      joystick;
    logic [1:0]                 rot;
    logic                       merge_joys;
    logic                       coin_auto;
    logic [4*PLAYERS-1:0]       p_dir;
    logic [BUTTONS*PLAYERS-1:0] p_btn;
    logic [PLAYERS-1:0]         p_start;
    logic [PLAYERS-1:0]         coin;
    logic                       pause;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .PLAYERS    (PLAYERS),
        .BUTTONS    (BUTTONS),
        .COIN_PULSE (COIN_PULSE)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .ps2_key    (ps2_key),
        .joystick   (joystick),
        .rot        (rot),
        .merge_joys (merge_joys),
        .coin_auto  (coin_auto),
        .p_dir      (p_dir),
        .p_btn      (p_btn),
        .p_start    (p_start),
        .coin       (coin),
        .pause      (pause)
    );

    typedef struct {
        logic [31:0] joy;
        logic [1:0]  rot;
        logic        merge;
        logic [7:0]  exp_dir;
        logic [3:0]  exp_btn;
        logic [1:0]  exp_start;
    } vec_t;

    vec_t vecs [13];

    localparam logic [31:0] P2_COIN  = 32'h0080_0000;
    localparam logic [31:0] P2_START = 32'h0040_0000;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        logic t;
        t = ps2_key[10];
        ps2_key = {~t, pressed, code};
    endtask

    task automatic mon(input int n, output int highs, output int rises);
        logic prev;
        prev  = coin[1];
        highs = 0;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (coin[1]) highs++;
            if (coin[1] && !prev) rises++;
            prev = coin[1];
        end
    endtask

    task automatic wait_coin(input logic lvl, input int limit, input string name);
        int n;
        n = 0;
        while (coin[1] !== lvl && n < limit) begin
            step();
            n++;
        end
        check(name, 32'(coin[1]), 32'(lvl));
    endtask

    initial begin
        int h, r;

        RESET_N    = 1'b0;
        ps2_key    = '0;
        joystick   = 32'h0000_007F;
        rot        = 2'd0;
        merge_joys = 1'b0;
        coin_auto  = 1'b0;

        //            joy           rot   mrg   dir     btn   start
        vecs[0]  = '{32'h0000_0000, 2'd0, 1'b0, 8'h00, 4'h0, 2'b00};
        vecs[1]  = '{32'h0000_0008, 2'd0, 1'b0, 8'h08, 4'h0, 2'b00};
        vecs[2]  = '{32'h0000_0008, 2'd1, 1'b0, 8'h01, 4'h0, 2'b00};
        vecs[3]  = '{32'h0000_0008, 2'd2, 1'b0, 8'h04, 4'h0, 2'b00};
        vecs[4]  = '{32'h0000_0008, 2'd3, 1'b0, 8'h02, 4'h0, 2'b00};
        vecs[5]  = '{32'h0001_0000, 2'd1, 1'b0, 8'h40, 4'h0, 2'b00};
        vecs[6]  = '{32'h0002_0005, 2'd0, 1'b0, 8'h25, 4'h0, 2'b00};
        vecs[7]  = '{32'h0020_0000, 2'd0, 1'b1, 8'h00, 4'hA, 2'b00};
        vecs[8]  = '{32'h0020_0000, 2'd0, 1'b0, 8'h00, 4'h8, 2'b00};
        vecs[9]  = '{32'h0008_0000, 2'd0, 1'b1, 8'h88, 4'h0, 2'b00};
        vecs[10] = '{32'h0040_0050, 2'd0, 1'b0, 8'h00, 4'h1, 2'b11};
        vecs[11] = '{32'h0040_0000, 2'd0, 1'b1, 8'h00, 4'h0, 2'b11};
        vecs[12] = '{32'h0000_000F, 2'd2, 1'b0, 8'h0F, 4'h0, 2'b00};

        step(3);
        check("reset_dir",   32'(p_dir),   32'h0);
        check("reset_btn",   32'(p_btn),   32'h0);
        check("reset_start", 32'(p_start), 32'h0);
        check("reset_coin",  32'(coin),    32'h0);
        check("reset_pause", 32'(pause),   32'h0);
        joystick = '0;
        @(negedge clk_sys);
        RESET_N = 1'b1;
        step(4);

        for (int i = 0; i < 13; i++) begin
            joystick   = vecs[i].joy;
            rot        = vecs[i].rot;
            merge_joys = vecs[i].merge;
            step();
            check($sformatf("vec%0d_dir", i),   32'(p_dir),   32'(vecs[i].exp_dir));
            check($sformatf("vec%0d_btn", i),   32'(p_btn),   32'(vecs[i].exp_btn));
            check($sformatf("vec%0d_start", i), 32'(p_start), 32'(vecs[i].exp_start));
        end
        joystick   = '0;
        rot        = 2'd0;
        merge_joys = 1'b0;
        step(2);

        send_key(1'b1, 9'h175);
        step();
        check("kb_up_lat1", 32'(p_dir), 32'h00);
        step();
        check("kb_up", 32'(p_dir), 32'h08);
        send_key(1'b0, 9'h175);
        step(2);
        check("kb_up_break", 32'(p_dir), 32'h00);
        send_key(1'b1, 9'h074);
        step(2);
        check("kb_right_noext", 32'(p_dir), 32'h01);
        send_key(1'b0, 9'h074);
        step(2);

        send_key(1'b1, 9'h029);
        joystick = 32'h0000_0020;
        step(2);
        check("kb_joy_or_btn", 32'(p_btn), 32'h3);
        send_key(1'b0, 9'h029);
        joystick = '0;
        step(2);
        check("kb_btn_release", 32'(p_btn), 32'h0);

        send_key(1'b1, 9'h006);
        step(2);
        check("kb_start2", 32'(p_start), 32'h2);
        send_key(1'b0, 9'h006);
        step(2);
        check("kb_start2_break", 32'(p_start), 32'h0);

        send_key(1'b1, 9'h04D);
        step(2);
        check("pause_make1", 32'(pause), 32'h1);
        send_key(1'b1, 9'h04D);
        step(2);
        check("pause_repeat", 32'(pause), 32'h1);
        send_key(1'b0, 9'h04D);
        step(2);
        check("pause_break", 32'(pause), 32'h1);
        send_key(1'b1, 9'h04D);
        step(2);
        check("pause_make2", 32'(pause), 32'h0);
        send_key(1'b0, 9'h04D);
        step(2);

        send_key(1'b1, 9'h036);
        step(2);
        check("kb_coin_lat2", 32'(coin), 32'h0);
        step();
        check("kb_coin_lat3", 32'(coin), 32'h2);
        send_key(1'b0, 9'h036);
        step(12);

        joystick = P2_COIN;
        step();
        check("coin_lat1", 32'(coin[1]), 32'h0);
        step();
        check("coin_lat2", 32'(coin[1]), 32'h1);
        mon(18, h, r);
        check("coin_held_width", 32'(h + 1), 32'(COIN_PULSE));
        check("coin_held_once", 32'(r), 32'h0);
        joystick = '0;
        step(10);

        joystick = P2_COIN;
        wait_coin(1'b1, 5, "gap_pulse_rise");
        wait_coin(1'b0, 8, "gap_pulse_fall");
        joystick = '0;
        step();
        joystick = P2_COIN;
        mon(14, h, r);
        check("gap_reraise_dropped", 32'(r), 32'h0);
        joystick = '0;
        step(5);
        joystick = P2_COIN;
        mon(14, h, r);
        check("second_pulse_rises", 32'(r), 32'h1);
        check("second_pulse_width", 32'(h), 32'(COIN_PULSE));
        joystick = '0;
        step(10);

        coin_auto = 1'b1;
        joystick  = P2_START;
        step(2);
        check("coin_auto_start", 32'(coin), 32'h2);
        joystick  = '0;
        step(10);
        coin_auto = 1'b0;

        joystick = P2_COIN;
        wait_coin(1'b1, 6, "rst_pre_high");
        step();
        #2 RESET_N = 1'b0;
        #1 check("rst_async_coin", 32'(coin), 32'h0);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        mon(14, h, r);
        check("rst_held_no_rise", 32'(r), 32'h0);
        check("rst_held_no_high", 32'(h), 32'h0);
        joystick = '0;
        step(3);
        joystick = P2_COIN;
        mon(14, h, r);
        check("rst_after_rises", 32'(r), 32'h1);
        check("rst_after_width", 32'(h), 32'(COIN_PULSE));
        joystick = '0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
